stopwatch_ctrl: RTL
===================

// Module: stopwatch_ctrl
// PURPOSE
//  Run/pause/terminal sequencer for the stopwatch BCD counter datapath.
//  - Debounces the raw P button and generates the 100 Hz count tick.
//  - Drives counter init/enable/direction from the sel mode switches.
//  - Sits between the top-level button/switch inputs and the counter/display block.
// PARAMETERS
//  CLK_HZ     100_000_000  input clock frequency
//  TICK_HZ    100          count-enable rate; DIV = CLK_HZ/TICK_HZ cycles per tick
//  DB_CYCLES  1_000_000    consecutive stable cycles for debounced P to change
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  R          in   1  reset, asynchronous, active-high
//  P          in   1  raw start/pause button, asynchronous to clk
//  sel        in   2  mode: [1]=0 up / 1 down; [0]=0 init constant / 1 init from load
//  tc_up      in   1  counter reads 99.99
//  tc_dn      in   1  counter reads 00.00
//  cnt_init   out  1  one-cycle pulse: counter takes initial value
//  init_src   out  1  0 = constant (00.00 up, 99.99 down), 1 = load switches
//  cnt_en     out  1  one-cycle pulse: counter steps once in cnt_dir
//  cnt_dir    out  1  1 = up, 0 = down
//  state      out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//  done       out  1  high in DONE (pulse per wrap with SW_AUTO_RESTART_EN)
// BEHAVIOUR
//  - Reset (R=1, async): state=IDLE; every output 0; synchronizer, debouncer and tick counter cleared.
//  - P input path:
//    - P passes through a 2-FF synchronizer.
//    - Debounced level changes only after DB_CYCLES identical consecutive synced samples.
//    - p_evt = one-cycle pulse on each debounced 0->1 edge. Release generates nothing.
//  - Tick counter:
//    - Counts 0..DIV-1 in RUN only; frozen (value held) in PAUSE; cleared in IDLE/DONE.
//    - tick=1 in the cycle the counter is at DIV-1; the counter wraps to 0 that cycle.
//    - First tick comes DIV cycles after RUN entry from IDLE.
//  - FSM, registered outputs:
//    - IDLE -p_evt-> RUN:
//      - latch cnt_dir = ~sel[1] and init_src = sel[0].
//      - cnt_init=1 for exactly the first RUN cycle.
//    - RUN -p_evt-> PAUSE.
//    - RUN -terminal-> DONE, where terminal = (cnt_dir & tc_up) | (~cnt_dir & tc_dn).
//    - PAUSE -p_evt-> RUN: no re-init; tick phase resumes where it froze.
//    - DONE -p_evt-> IDLE.
//  - cnt_en = tick & (state==RUN) & ~terminal & ~cnt_init. Never asserted outside RUN.
//  - Terminal is ignored in the cnt_init cycle, because tc is stale until the counter has loaded.
//    An init value that is already terminal gives DONE one cycle later.
//  - sel changes outside IDLE are ignored until the next IDLE->RUN.
//  - Simultaneous events in RUN:
//    - tick & p_evt: cnt_en still pulses that cycle; PAUSE next cycle.
//    - terminal & p_evt: DONE wins; the press is discarded.
//  - Latency: p_evt to state change = 1 cycle; raw P edge to p_evt = 2 + DB_CYCLES cycles.
//  - Mid-operation R: immediate IDLE. The counter value is owned by the datapath and is not cleared here.
// CONFIGURATION
//  - SW_AUTO_RESTART_EN defined:
//    - On terminal in RUN, stay in RUN.
//    - Re-issue cnt_init next cycle; done pulses 1 cycle; tick phase cleared.
//    - DONE is unreachable.
//  - SW_AUTO_RESTART_EN undefined: terminal enters DONE and holds until p_evt.
// TESTING (bench params CLK_HZ=1000, TICK_HZ=100 -> DIV=10, DB_CYCLES=4)
//  1. R pulsed high mid-RUN -> state=00, cnt_en/cnt_init/done=0 in the same cycle, without waiting for a clk edge.
//  2. sel=00, P held 8 cycles:
//     - p_evt 6 cycles after the P rise.
//     - Next cycle: state=01, cnt_init=1 for 1 cycle, init_src=0, cnt_dir=1.
//     - cnt_en at RUN+10, RUN+20, ...
//  3. P toggles every 2 cycles for 40 cycles, then stays 0 -> no p_evt, state stays 00.
//  4. Press in RUN at tick phase 6 -> PAUSE, no cnt_en; press again -> RUN, first cnt_en 4 cycles after resume.
//  5. sel=11, tc_dn forced 1 after 3 ticks:
//     - No cnt_en that cycle; state=11, done=1; press -> state=00.
//     - With SW_AUTO_RESTART_EN: cnt_init next cycle, done 1-cycle pulse, state stays 01.
//  6. p_evt in the same cycle as tick in RUN -> cnt_en=1 that cycle, state=10 next cycle.
//     p_evt in the same cycle as terminal -> state=11.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Run/pause/terminal sequencer for the stopwatch BCD counter: P button sync + debounce,
// count-tick divider and mode FSM. Define SW_AUTO_RESTART_EN to re-init on terminal instead of stopping.
module stopwatch_ctrl #(
   parameter int CLK_HZ    = 100_000_000,
   parameter int TICK_HZ   = 100,
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       R,
   input  logic       P,
   input  logic [1:0] sel,
   input  logic       tc_up,
   input  logic       tc_dn,
   output logic       cnt_init,
   output logic       init_src,
   output logic       cnt_en,
   output logic       cnt_dir,
   output logic [1:0] state,
   output logic       done
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int DW  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
   localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   logic [1:0]    r_sync;
   logic          r_db;
   logic [DW-1:0] r_db_cnt;
   logic          r_p_evt;

   state_t        r_state;
   logic          r_cnt_init;
   logic          r_init_src;
   logic          r_cnt_dir;
   logic          r_done;
   logic [TW-1:0] r_tick_cnt;

   logic w_tick;
   logic w_terminal;
   logic w_term_live;

   // Debounced level flips only after DB_CYCLES consecutive disagreeing synced samples.
   always_ff @(posedge clk or posedge R) begin
      if (R) begin
         r_sync   <= 2'b00;
         r_db     <= 1'b0;
         r_db_cnt <= '0;
         r_p_evt  <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], P};
         r_p_evt <= 1'b0;
         if (r_sync[1] == r_db) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == DB_LAST) begin
            r_db     <= r_sync[1];
            r_db_cnt <= '0;
            r_p_evt  <= r_sync[1];
         end else begin
            r_db_cnt <= r_db_cnt + DW'(1);
         end
      end
   end

   assign w_tick      = (r_state == S_RUN) && (r_tick_cnt == TICK_LAST);
   assign w_terminal  = (r_cnt_dir & tc_up) | (~r_cnt_dir & tc_dn);
   // tc is stale while the counter is still loading its initial value.
   assign w_term_live = (r_state == S_RUN) & w_terminal & ~r_cnt_init;

   always_ff @(posedge clk or posedge R) begin
      if (R) begin
         r_state    <= S_IDLE;
         r_cnt_init <= 1'b0;
         r_init_src <= 1'b0;
         r_cnt_dir  <= 1'b0;
         r_done     <= 1'b0;
         r_tick_cnt <= '0;
      end else begin
         r_cnt_init <= 1'b0;
`ifdef SW_AUTO_RESTART_EN
         r_done     <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               r_tick_cnt <= '0;
               if (r_p_evt) begin
                  r_state    <= S_RUN;
                  r_cnt_init <= 1'b1;
                  r_cnt_dir  <= ~sel[1];
                  r_init_src <= sel[0];
               end
            end
            S_RUN: begin
               r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
               if (w_term_live) begin
`ifdef SW_AUTO_RESTART_EN
                  r_cnt_init <= 1'b1;
                  r_done     <= 1'b1;
                  r_tick_cnt <= '0;
`else
                  r_state    <= S_DONE;
                  r_done     <= 1'b1;
`endif
               end else if (r_p_evt) begin
                  r_state <= S_PAUSE;
               end
            end
            S_PAUSE: begin
               if (r_p_evt) r_state <= S_RUN;
            end
            S_DONE: begin
               r_tick_cnt <= '0;
               if (r_p_evt) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cnt_en   = w_tick & ~w_terminal & ~r_cnt_init;
   assign cnt_init = r_cnt_init;
   assign init_src = r_init_src;
   assign cnt_dir  = r_cnt_dir;
   assign state    = r_state;
   assign done     = r_done;

endmodule
